// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game-flow FSM for the T-rex game.
// Tracks lives, a post-hit invulnerability window, pause/resume of the
// RUN or HIT state, and frame-paced difficulty levels.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   jump       in   start request pulse
//   restart    in   return-to-title pulse
//   pause      in   pause/resume toggle pulse
//   collided   in   obstacle hit this cycle
//   frame_tick in   one-cycle pulse per video frame
//   state      out  INIT=000 RUN=010 HIT=011 PAUSE=100 DEAD=001
//   lives      out  remaining lives
//   level      out  current difficulty level
//   invuln     out  high exactly while state==HIT
//   game_over  out  one-cycle pulse when DEAD is entered
//
// Build option: define GAME_FLOW_EXTRA_LIFE_EN to grant +1 life (saturating
// at MAX_LIVES) on every level increment.
module game_flow_ctrl #(
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned MAX_LIVES     = 7,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned LEVEL_FRAMES  = 600,
    parameter int unsigned NUM_LEVELS    = 8,
    localparam int unsigned LIFE_W = $clog2(MAX_LIVES + 1),
    localparam int unsigned LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump,
    input  logic              restart,
    input  logic              pause,
    input  logic              collided,
    input  logic              frame_tick,
    output logic [2:0]        state,
    output logic [LIFE_W-1:0] lives,
    output logic [LVL_W-1:0]  level,
    output logic              invuln,
    output logic              game_over
);

    localparam int unsigned LFC_W = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;
    localparam int unsigned INV_W = $clog2(INVULN_FRAMES + 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'b000,
        S_DEAD  = 3'b001,
        S_RUN   = 3'b010,
        S_HIT   = 3'b011,
        S_PAUSE = 3'b100
    } state_t;

    state_t            state_q, state_d;
    logic              saved_hit_q, saved_hit_d;   // 1: PAUSE resumes to HIT
    logic [LIFE_W-1:0] lives_q, lives_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [LFC_W-1:0]  lvl_cnt_q, lvl_cnt_d;
    logic [INV_W-1:0]  inv_cnt_q, inv_cnt_d;
    logic              invuln_q, invuln_d;
    logic              game_over_q, game_over_d;
`ifdef GAME_FLOW_EXTRA_LIFE_EN
    logic              lvl_up;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            saved_hit_q <= 1'b0;
            lives_q     <= LIFE_W'(START_LIVES);
            level_q     <= '0;
            lvl_cnt_q   <= '0;
            inv_cnt_q   <= '0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_hit_q <= saved_hit_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            lvl_cnt_q   <= lvl_cnt_d;
            inv_cnt_q   <= inv_cnt_d;
            invuln_q    <= invuln_d;
            game_over_q <= game_over_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        saved_hit_d = saved_hit_q;
        lives_d     = lives_q;
        level_d     = level_q;
        lvl_cnt_d   = lvl_cnt_q;
        inv_cnt_d   = inv_cnt_q;
        game_over_d = 1'b0;
`ifdef GAME_FLOW_EXTRA_LIFE_EN
        lvl_up      = 1'b0;
`endif

        // Level pacing runs on the current state, so the tick is counted even
        // on a cycle where the FSM leaves RUN/HIT.
        if ((state_q == S_RUN || state_q == S_HIT) && frame_tick) begin
            if (lvl_cnt_q == LFC_W'(LEVEL_FRAMES - 1)) begin
                lvl_cnt_d = '0;
                if (level_q != LVL_W'(NUM_LEVELS - 1)) begin
                    level_d = level_q + 1'b1;
`ifdef GAME_FLOW_EXTRA_LIFE_EN
                    lvl_up  = 1'b1;
`endif
                end
            end else begin
                lvl_cnt_d = lvl_cnt_q + 1'b1;
            end
        end

`ifdef GAME_FLOW_EXTRA_LIFE_EN
        // Bonus is the default; the RUN collision path overrides it below.
        if (lvl_up && lives_q != LIFE_W'(MAX_LIVES))
            lives_d = lives_q + 1'b1;
`endif

        case (state_q)
            S_INIT: begin
                if (jump) begin
                    state_d   = S_RUN;
                    lives_d   = LIFE_W'(START_LIVES);
                    level_d   = '0;
                    lvl_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (collided) begin
                    if (lives_q == LIFE_W'(1)) begin
                        state_d     = S_DEAD;
                        lives_d     = '0;
                        game_over_d = 1'b1;
                    end else begin
                        state_d   = S_HIT;
                        inv_cnt_d = INV_W'(INVULN_FRAMES);
`ifdef GAME_FLOW_EXTRA_LIFE_EN
                        lives_d   = lvl_up ? lives_q : lives_q - 1'b1;
`else
                        lives_d   = lives_q - 1'b1;
`endif
                    end
                end else if (pause) begin
                    saved_hit_d = 1'b0;
                    state_d     = S_PAUSE;
                end
            end
            S_HIT: begin
                if (pause) begin
                    saved_hit_d = 1'b1;
                    state_d     = S_PAUSE;
                end else if (frame_tick) begin
                    inv_cnt_d = inv_cnt_q - 1'b1;
                    if (inv_cnt_q == INV_W'(1))
                        state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (restart)
                    state_d = S_INIT;
                else if (pause)
                    state_d = saved_hit_q ? S_HIT : S_RUN;
            end
            S_DEAD: begin
                if (restart || jump)
                    state_d = S_INIT;
            end
            default: state_d = S_INIT;
        endcase

        invuln_d = (state_d == S_HIT);
    end

    assign state     = state_q;
    assign lives     = lives_q;
    assign level     = level_q;
    assign invuln    = invuln_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus a random
// run compared against a behavioural model of the game rules.
module tb_game_flow_ctrl;

    localparam int unsigned START_LIVES   = 3;
    localparam int unsigned MAX_LIVES     = 7;
    localparam int unsigned INVULN_FRAMES = 4;
    localparam int unsigned LEVEL_FRAMES  = 3;
    localparam int unsigned NUM_LEVELS    = 4;
    localparam int unsigned LIFE_W        = 3;
    localparam int unsigned LVL_W         = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0, jump = 1'b0, restart = 1'b0, pause = 1'b0;
    logic              collided = 1'b0, frame_tick = 1'b0;
    logic [2:0]        state;
    logic [LIFE_W-1:0] lives;
    logic [LVL_W-1:0]  level;
    logic              invuln, game_over;

    int errors = 0;
    int checks = 0;

    game_flow_ctrl #(
        .START_LIVES  (START_LIVES),
        .MAX_LIVES    (MAX_LIVES),
        .INVULN_FRAMES(INVULN_FRAMES),
        .LEVEL_FRAMES (LEVEL_FRAMES),
        .NUM_LEVELS   (NUM_LEVELS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .jump      (jump),
        .restart   (restart),
        .pause     (pause),
        .collided  (collided),
        .frame_tick(frame_tick),
        .state     (state),
        .lives     (lives),
        .level     (level),
        .invuln    (invuln),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // Behavioural model: game phase as a plain number, counts as ints.
    // phase: 0 title, 1 running, 2 hit/invulnerable, 3 paused, 4 dead
    int m_ph = 0;
    bit m_resume_hit = 0;
    int m_lives = START_LIVES;
    int m_level = 0;
    int m_frames = 0;
    int m_inv = 0;
    bit m_go = 0;

    function automatic logic [2:0] ph_code(input int ph);
        case (ph)
            1:       return 3'b010;
            2:       return 3'b011;
            3:       return 3'b100;
            4:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_update(input bit r, j, rs, p, c, f);
        bit bonus;
        bonus = 0;
        if (r) begin
            m_ph = 0; m_resume_hit = 0; m_lives = START_LIVES; m_level = 0;
            m_frames = 0; m_inv = 0; m_go = 0;
            return;
        end
        m_go = 0;
        if ((m_ph == 1 || m_ph == 2) && f) begin
            m_frames++;
            if (m_frames == LEVEL_FRAMES) begin
                m_frames = 0;
                if (m_level < NUM_LEVELS - 1) begin
                    m_level++;
                    bonus = 1;
                end
            end
        end
`ifndef GAME_FLOW_EXTRA_LIFE_EN
        bonus = 0;
`endif
        case (m_ph)
            0: if (j) begin
                m_ph = 1; m_lives = START_LIVES; m_level = 0; m_frames = 0;
            end
            1: begin
                if (c) begin
                    if (m_lives == 1) begin
                        m_ph = 4; m_lives = 0; m_go = 1;
                    end else begin
                        m_lives = m_lives - 1 + (bonus ? 1 : 0);
                        m_inv = INVULN_FRAMES;
                        m_ph = 2;
                    end
                end else begin
                    if (bonus && m_lives < MAX_LIVES) m_lives++;
                    if (p) begin m_resume_hit = 0; m_ph = 3; end
                end
            end
            2: begin
                if (bonus && m_lives < MAX_LIVES) m_lives++;
                if (p) begin
                    m_resume_hit = 1; m_ph = 3;
                end else if (f) begin
                    if (m_inv == 1) m_ph = 1;
                    m_inv--;
                end
            end
            3: begin
                if (rs) m_ph = 0;
                else if (p) m_ph = m_resume_hit ? 2 : 1;
            end
            4: if (rs || j) m_ph = 0;
            default: m_ph = 0;
        endcase
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit r, j, rs, p, c, f);
        rst = r; jump = j; restart = rs; pause = p; collided = c; frame_tick = f;
        model_update(r, j, rs, p, c, f);
        @(posedge clk);
        #1;
        rst = 0; jump = 0; restart = 0; pause = 0; collided = 0; frame_tick = 0;
    endtask

    task automatic start_game();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        checks++; if (state !== 3'b000) begin errors++; $display("FAIL reset_state got=%b exp=000", state); end
        checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives got=%0d exp=3", lives); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (invuln !== 1'b0 || game_over !== 1'b0) begin
            errors++; $display("FAIL reset_flags got=%b%b exp=00", invuln, game_over);
        end
        step(0, 1, 0, 0, 0, 0);
        checks++; if (state !== 3'b010) begin errors++; $display("FAIL start_state got=%b exp=010", state); end
    endtask

    task automatic test_hit();
        start_game();
        step(0, 0, 0, 0, 1, 0);
        checks++; if (state !== 3'b011 || lives !== 3'd2 || invuln !== 1'b1) begin
            errors++; $display("FAIL hit_enter got st=%b lives=%0d inv=%b exp st=011 lives=2 inv=1", state, lives, invuln);
        end
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 1, 0);
            checks++; if (state !== 3'b011 || lives !== 3'd2) begin
                errors++; $display("FAIL hit_collide_ignored got st=%b lives=%0d exp st=011 lives=2", state, lives);
            end
            step(0, 0, 0, 0, 0, 1);
            if (i < 4) begin
                checks++; if (state !== 3'b011 || invuln !== 1'b1) begin
                    errors++; $display("FAIL hit_window tick=%0d got st=%b inv=%b exp st=011 inv=1", i, state, invuln);
                end
            end else begin
                checks++; if (state !== 3'b010 || invuln !== 1'b0) begin
                    errors++; $display("FAIL hit_exit got st=%b inv=%b exp st=010 inv=0", state, invuln);
                end
            end
        end
    endtask

    task automatic test_fatal();
        int guard;
        start_game();
        guard = 0;
        // Burn lives down to one; each hit window is ridden out with ticks.
        while (m_lives > 1 && guard < 50) begin
            step(0, 0, 0, 0, 1, 0);
            for (int k = 0; k < 8 && m_ph != 1; k++) step(0, 0, 0, 0, 0, 1);
            guard++;
        end
        checks++; if (guard >= 50 || lives !== 3'd1 || state !== 3'b010) begin
            errors++; $display("FAIL fatal_setup got st=%b lives=%0d exp st=010 lives=1", state, lives);
        end
        step(0, 0, 0, 0, 1, 0);
        checks++; if (state !== 3'b001 || lives !== 3'd0 || game_over !== 1'b1) begin
            errors++; $display("FAIL fatal_enter got st=%b lives=%0d go=%b exp st=001 lives=0 go=1", state, lives, game_over);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++; if (game_over !== 1'b0 || state !== 3'b001) begin
            errors++; $display("FAIL fatal_pulse got st=%b go=%b exp st=001 go=0", state, game_over);
        end
        step(0, 0, 1, 0, 0, 0);
        checks++; if (state !== 3'b000 || lives !== 3'd0) begin
            errors++; $display("FAIL dead_restart got st=%b lives=%0d exp st=000 lives=0", state, lives);
        end
        step(0, 1, 0, 0, 0, 0);
        checks++; if (state !== 3'b010 || lives !== 3'd3 || level !== 2'd0) begin
            errors++; $display("FAIL restart_jump got st=%b lives=%0d lvl=%0d exp st=010 lives=3 lvl=0", state, lives, level);
        end
    endtask

    task automatic test_pause_hit();
        logic [LIFE_W-1:0] l0;
        logic [LVL_W-1:0]  v0;
        start_game();
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        checks++; if (state !== 3'b100 || invuln !== 1'b0) begin
            errors++; $display("FAIL pause_enter got st=%b inv=%b exp st=100 inv=0", state, invuln);
        end
        l0 = 3'(m_lives);
        v0 = 2'(m_level);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, (i % 3) == 0, 1);
            checks++; if (state !== 3'b100 || lives !== l0 || level !== v0) begin
                errors++; $display("FAIL pause_frozen got st=%b lives=%0d lvl=%0d exp st=100 lives=%0d lvl=%0d", state, lives, level, l0, v0);
            end
        end
        step(0, 0, 0, 1, 0, 0);
        checks++; if (state !== 3'b011 || invuln !== 1'b1) begin
            errors++; $display("FAIL pause_resume got st=%b inv=%b exp st=011 inv=1", state, invuln);
        end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (state !== 3'b011) begin errors++; $display("FAIL resume_tick3 got st=%b exp=011", state); end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (state !== 3'b010 || invuln !== 1'b0) begin
            errors++; $display("FAIL resume_exit got st=%b inv=%b exp st=010 inv=0", state, invuln);
        end
    endtask

    task automatic test_levels();
        int exp_lvl;
        int exp_lives;
        start_game();
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 0, 0, 1);
            exp_lvl = (i / 3 > 3) ? 3 : i / 3;
            checks++; if (level !== 2'(exp_lvl)) begin
                errors++; $display("FAIL level_tick%0d got=%0d exp=%0d", i, level, exp_lvl);
            end
        end
`ifdef GAME_FLOW_EXTRA_LIFE_EN
        exp_lives = 6;
`else
        exp_lives = 3;
`endif
        checks++; if (lives !== 3'(exp_lives)) begin
            errors++; $display("FAIL level_lives got=%0d exp=%0d", lives, exp_lives);
        end
    endtask

    task automatic test_simultaneous();
        start_game();
        step(0, 0, 0, 1, 1, 0);
        checks++; if (state !== 3'b011 || lives !== 3'd2) begin
            errors++; $display("FAIL collide_beats_pause got st=%b lives=%0d exp st=011 lives=2", state, lives);
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        checks++; if (state !== 3'b000) begin errors++; $display("FAIL restart_beats_pause got st=%b exp=000", state); end
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1, 1);
        checks++; if (state !== 3'b000 || lives !== 3'd3 || invuln !== 1'b0 || level !== 2'd0) begin
            errors++; $display("FAIL reset_in_hit got st=%b lives=%0d inv=%b lvl=%0d exp st=000 lives=3 inv=0 lvl=0", state, lives, invuln, level);
        end
    endtask

    task automatic test_random();
        bit r, j, rs, p, c, f;
        step(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            j  = ($urandom_range(0, 99) < 12);
            rs = ($urandom_range(0, 99) < 4);
            p  = ($urandom_range(0, 99) < 8);
            c  = ($urandom_range(0, 99) < 10);
            f  = ($urandom_range(0, 99) < 50);
            step(r, j, rs, p, c, f);
            checks++;
            if (state !== ph_code(m_ph) || lives !== 3'(m_lives) || level !== 2'(m_level) ||
                invuln !== (m_ph == 2) || game_over !== m_go) begin
                errors++;
                $display("FAIL random_cycle%0d got st=%b lives=%0d lvl=%0d inv=%b go=%b exp st=%b lives=%0d lvl=%0d inv=%b go=%b",
                         n, state, lives, level, invuln, game_over,
                         ph_code(m_ph), m_lives, m_level, (m_ph == 2), m_go);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_fatal();
        test_pause_hit();
        test_levels();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised top-level game-flow FSM for the T-rex game. It supersedes the 3-state init/in-game/dead controller and adds multiple lives, a post-hit invulnerability window, pause/resume and frame-paced difficulty levels. It sits between the input conditioner (jump/restart/pause pulses), the collision detector and the renderer/obstacle generator, which consume `state`, `level` and `invuln`.

Parameters:
- START_LIVES, 3: lives loaded on game start; must be ≥1 and ≤ MAX_LIVES.
- MAX_LIVES, 7: life-counter ceiling; sets LIFE_W = $clog2(MAX_LIVES+1).
- INVULN_FRAMES, 60: frame_tick count spent in HIT after a non-fatal collision; must be ≥1.
- LEVEL_FRAMES, 600: frame_ticks of play per level advance; must be ≥1.
- NUM_LEVELS, 8: number of levels; level saturates at NUM_LEVELS-1; LVL_W = max(1, $clog2(NUM_LEVELS)).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- jump, in, 1: start request; single-cycle pulse.
- restart, in, 1: return-to-title request; pulse.
- pause, in, 1: pause/resume toggle; pulse.
- collided, in, 1: obstacle hit this cycle.
- frame_tick, in, 1: one-cycle pulse per video frame.
- state, out, 3: INIT=3'b000, RUN=3'b010, HIT=3'b011, PAUSE=3'b100, DEAD=3'b001.
- lives, out, LIFE_W: remaining lives.
- level, out, LVL_W: current difficulty level.
- invuln, out, 1: high exactly while state==HIT.
- game_over, out, 1: one-cycle pulse on the cycle DEAD is entered.

Behaviour:
- All outputs are registered. Reset is synchronous, active-high; one clock; rst has priority in every state.
- On rst: state=INIT, lives=START_LIVES, level=0, invuln=0, game_over=0. Frame, invulnerability and saved-state registers are cleared.
- INIT: on jump, go to RUN and reload lives=START_LIVES, level=0, level frame counter=0. Other inputs are ignored.
- RUN, collided:
  - If lives==1: go to DEAD, set lives=0, pulse game_over.
  - Otherwise: go to HIT, decrement lives, load invuln counter=INVULN_FRAMES.
- RUN, pause without collided: save RUN, go to PAUSE. collided has priority over pause in the same cycle.
- HIT:
  - collided is ignored.
  - Each frame_tick decrements the invuln counter. When a frame_tick sees counter==1, go to RUN; invuln drops together with the state change.
  - pause: save HIT, go to PAUSE. The invuln counter is frozen while paused.
- PAUSE:
  - pause returns to the saved state (RUN or HIT) with all counters unchanged.
  - restart goes to INIT. If pause and restart arrive together, restart wins.
  - frame_tick and collided are ignored.
- DEAD: restart or jump goes to INIT. lives and level hold their final values until INIT is left via jump.
- Level pacing:
  - In RUN or HIT, every frame_tick increments the level frame counter, including the cycle a transition happens.
  - When the counter reaches LEVEL_FRAMES-1 and a tick arrives, the counter wraps to 0 and level increments, saturating at NUM_LEVELS-1.
  - The counter does not run in INIT, PAUSE or DEAD.
- Widths: all counters are unsigned. Lives never underflows below 0 and never exceeds MAX_LIVES.
- Unused state encodings go to INIT on the next clock.

Optional Feature:
- Macro: GAME_FLOW_EXTRA_LIFE_EN.
- Defined: each level increment also grants +1 life, saturating at MAX_LIVES. If a level-up coincides with a collision, both apply in the same cycle (net lives unchanged when not fatal). A collision with lives==1 is still fatal and takes precedence.
- Undefined: lives change only on INIT reload and collisions; no extra-life logic is synthesised.

Test Plan:
1. Reset and start: assert rst 2 cycles, then jump pulse → state=000 after reset with lives=3, level=0; state=010 the cycle after jump.
2. Non-fatal hit: in RUN with lives=3, collided pulse → state=011, lives=2, invuln=1. With INVULN_FRAMES=4, collisions during HIT are ignored; the 4th frame_tick returns state=010 and invuln=0.
3. Fatal hit: lives=1 in RUN, collided → state=001, lives=0, game_over high for exactly 1 cycle. Then restart → 000; then jump → 010 with lives=3.
4. Pause from HIT: after 2 of 4 invuln ticks, pause → state=100. 10 frame_ticks plus collided while paused change nothing. pause → state=011; 2 more ticks → 010.
5. Levels: with LEVEL_FRAMES=3 and NUM_LEVELS=4, 12 frame_ticks in RUN → level goes 1,2,3 then holds at 3. Macro on with START_LIVES=3 → lives=6; macro off → lives=3.
6. Simultaneity and reset priority: collided+pause in RUN → HIT (no pause). restart+pause in PAUSE → INIT. rst asserted in HIT mid-window → INIT with lives=3 and invuln=0 next cycle.
